// File: rtl/navigation_turn_queue_if.sv
// navigation_turn_queue_if
//   Bundles the button levels, shared move tick / pause, and the per-player
//   direction and status outputs of navigation_turn_queue.
//   master : stimulus side (drives buttons, MOVE_TICK, PAUSE)
//   slave  : controller side (drives Navigation_State, QUEUE_FULL,
//            TURN_TAKEN, DROP)
interface navigation_turn_queue_if #(
  parameter int N_PLAYERS = 2
);
  logic [N_PLAYERS-1:0]   BINL;
  logic [N_PLAYERS-1:0]   BINU;
  logic [N_PLAYERS-1:0]   BIND;
  logic [N_PLAYERS-1:0]   BINR;
  logic                   MOVE_TICK;
  logic                   PAUSE;
  logic [2*N_PLAYERS-1:0] Navigation_State;
  logic [N_PLAYERS-1:0]   QUEUE_FULL;
  logic [N_PLAYERS-1:0]   TURN_TAKEN;
  logic [N_PLAYERS-1:0]   DROP;

  modport master (
    output BINL, BINU, BIND, BINR, MOVE_TICK, PAUSE,
    input  Navigation_State, QUEUE_FULL, TURN_TAKEN, DROP
  );

  modport slave (
    input  BINL, BINU, BIND, BINR, MOVE_TICK, PAUSE,
    output Navigation_State, QUEUE_FULL, TURN_TAKEN, DROP
  );
endinterface

// File: rtl/navigation_turn_queue.sv
// navigation_turn_queue
//   Per-player snake direction controller. Button rising edges become turn
//   requests, legal requests are buffered in a per-player FIFO, and one
//   buffered turn is applied per MOVE_TICK. PAUSE freezes ticks and capture.
//   Ports:
//     CLK   : clock, posedge
//     RESET : synchronous active-low reset
//     nav   : navigation_turn_queue_if.slave (buttons, tick, pause in;
//             Navigation_State / QUEUE_FULL / TURN_TAKEN / DROP out)
//   Direction codes: 00 Up, 01 Down, 10 Left, 11 Right.

// One player's edge detector, validity check and turn FIFO.
module navigation_turn_lane #(
  parameter int         QUEUE_DEPTH   = 4,
  parameter logic [1:0] RESET_DIR     = 2'b00,
  parameter int         ALLOW_REVERSE = 0
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [3:0] btn,        // {L, U, D, R} levels
  input  logic       move_tick,
  input  logic       pause,
  output logic [1:0] dir,
  output logic       full,
  output logic       turn_taken,
  output logic       drop
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] DIR_U = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_R = 2'b11;

  logic [3:0]                  hist;
  logic [3:0]                  edges;
  logic [QUEUE_DEPTH-1:0][1:0] fifo;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [1:0]                  req_dir, ref_dir;
  logic                        multi, empty, is_full, legal, pop, take, push, drop_nxt;

  assign edges = btn & ~hist;

  // Priority L > U > D > R; multi flags a losing edge alongside the winner.
  always_comb begin
    req_dir = DIR_U;
    multi   = 1'b0;
    priority casez (edges)
      4'b1???: begin req_dir = DIR_L; multi = |edges[2:0]; end
      4'b01??: begin req_dir = DIR_U; multi = |edges[1:0]; end
      4'b001?: begin req_dir = DIR_D; multi = edges[0];    end
      4'b0001: begin req_dir = DIR_R; multi = 1'b0;        end
      default: begin req_dir = DIR_U; multi = 1'b0;        end
    endcase
  end

  assign empty   = (count == '0);
  assign is_full = (count == CW'(QUEUE_DEPTH));

  // New turns are judged against the last buffered turn, not the live
  // direction, so a burst of presses builds a consistent path.
  assign ref_dir = empty ? dir : fifo[wr_ptr - PW'(1)];
  assign legal   = (ALLOW_REVERSE != 0) ? (req_dir != ref_dir)
                                        : (req_dir[1] != ref_dir[1]);

  assign pop      = move_tick & ~pause & ~empty;
  assign take     = (|edges) & ~pause & legal;
  // A pop in the same cycle frees the slot a full queue needs.
  assign push     = take & (~is_full | pop);
  assign drop_nxt = take & ((is_full & ~pop) | multi);

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      hist       <= 4'hF;
      dir        <= RESET_DIR;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      turn_taken <= 1'b0;
      drop       <= 1'b0;
    end else begin
      hist       <= btn;
      turn_taken <= pop;
      drop       <= drop_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        dir    <= fifo[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge gclk) begin
    if (push) fifo[wr_ptr] <= req_dir;
  end

  assign full = is_full;
endmodule

module navigation_turn_queue #(
  parameter int         N_PLAYERS     = 2,
  parameter int         QUEUE_DEPTH   = 4,
  parameter logic [1:0] RESET_DIR     = 2'b00,
  parameter int         ALLOW_REVERSE = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  navigation_turn_queue_if.slave   nav
);
  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_lane
    navigation_turn_lane #(
      .QUEUE_DEPTH  (QUEUE_DEPTH),
      .RESET_DIR    (RESET_DIR),
      .ALLOW_REVERSE(ALLOW_REVERSE)
    ) u_lane (
      .gclk      (CLK),
      .grst_n    (RESET),
      .btn       ({nav.BINL[p], nav.BINU[p], nav.BIND[p], nav.BINR[p]}),
      .move_tick (nav.MOVE_TICK),
      .pause     (nav.PAUSE),
      .dir       (nav.Navigation_State[2*p +: 2]),
      .full      (nav.QUEUE_FULL[p]),
      .turn_taken(nav.TURN_TAKEN[p]),
      .drop      (nav.DROP[p])
    );
  end
endmodule

// File: tb/tb_navigation_turn_queue.sv
module tb_navigation_turn_queue;
  localparam int NP = 2;
  localparam int QD = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic [NP-1:0] bl = '0, bu = '0, bd = '0, br = '0;
  logic tick = 1'b0, pause = 1'b0;

  navigation_turn_queue_if #(.N_PLAYERS(NP)) nav0 ();
  navigation_turn_queue_if #(.N_PLAYERS(NP)) nav1 ();

  assign nav0.BINL = bl;  assign nav1.BINL = bl;
  assign nav0.BINU = bu;  assign nav1.BINU = bu;
  assign nav0.BIND = bd;  assign nav1.BIND = bd;
  assign nav0.BINR = br;  assign nav1.BINR = br;
  assign nav0.MOVE_TICK = tick;  assign nav1.MOVE_TICK = tick;
  assign nav0.PAUSE = pause;     assign nav1.PAUSE = pause;

  navigation_turn_queue #(.N_PLAYERS(NP), .QUEUE_DEPTH(QD), .RESET_DIR(2'b00), .ALLOW_REVERSE(0))
    dut0 (.CLK(CLK), .RESET(RESET), .nav(nav0));
  navigation_turn_queue #(.N_PLAYERS(NP), .QUEUE_DEPTH(QD), .RESET_DIR(2'b00), .ALLOW_REVERSE(1))
    dut1 (.CLK(CLK), .RESET(RESET), .nav(nav1));

  // Behavioural model: index d=0 is the perpendicular-only DUT, d=1 the reverse-allowed DUT.
  logic [1:0] ms [2][NP];
  logic [1:0] mq [2][NP][$];
  bit         mtt [2][NP];
  bit         mdrop [2][NP];
  bit [3:0]   mh [NP];   // previous levels, index 0=L 1=U 2=D 3=R
  bit         en = 1'b0;
  int         errors = 0, checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [1:0] code [4];
    code[0] = 2'b10; code[1] = 2'b00; code[2] = 2'b01; code[3] = 2'b11;
    for (int p = 0; p < NP; p++) begin
      bit [3:0] now;
      now = {br[p], bd[p], bu[p], bl[p]};
      for (int d = 0; d < 2; d++) begin
        if (!RESET) begin
          ms[d][p] = 2'b00;
          mq[d][p].delete();
          mtt[d][p] = 1'b0;
          mdrop[d][p] = 1'b0;
        end else begin
          int n, w;
          logic [1:0] req, refd;
          bit pop, ok, dopush;
          n = 0; w = -1;
          for (int i = 0; i < 4; i++)
            if (now[i] && !mh[p][i]) begin
              n++;
              if (w < 0) w = i;
            end
          req = (w >= 0) ? code[w] : 2'b00;
          refd = (mq[d][p].size() > 0) ? mq[d][p][$] : ms[d][p];
          ok = (d == 1) ? (req != refd) : (req[1] != refd[1]);
          pop = tick && !pause && (mq[d][p].size() > 0);
          mtt[d][p] = pop;
          mdrop[d][p] = 1'b0;
          dopush = 1'b0;
          if (n > 0 && !pause && ok) begin
            if (mq[d][p].size() == QD && !pop) mdrop[d][p] = 1'b1;
            else dopush = 1'b1;
            if (n > 1) mdrop[d][p] = 1'b1;
          end
          if (pop) ms[d][p] = mq[d][p].pop_front();
          if (dopush) mq[d][p].push_back(req);
        end
      end
      mh[p] = RESET ? now : 4'hF;
    end
    if (!RESET) en = 1'b1;
  endtask

  task automatic compare_model();
    for (int d = 0; d < 2; d++) begin
      logic [2*NP-1:0] es;
      logic [NP-1:0] ef, et, ed;
      for (int p = 0; p < NP; p++) begin
        es[2*p +: 2] = ms[d][p];
        ef[p] = (mq[d][p].size() == QD);
        et[p] = mtt[d][p];
        ed[p] = mdrop[d][p];
      end
      if (d == 0) begin
        chk("m0_state", 8'(nav0.Navigation_State), 8'(es));
        chk("m0_full",  8'(nav0.QUEUE_FULL), 8'(ef));
        chk("m0_taken", 8'(nav0.TURN_TAKEN), 8'(et));
        chk("m0_drop",  8'(nav0.DROP), 8'(ed));
      end else begin
        chk("m1_state", 8'(nav1.Navigation_State), 8'(es));
        chk("m1_full",  8'(nav1.QUEUE_FULL), 8'(ef));
        chk("m1_taken", 8'(nav1.TURN_TAKEN), 8'(et));
        chk("m1_drop",  8'(nav1.DROP), 8'(ed));
      end
    end
  endtask

  // Compare at negedge, advance model at posedge, return 2ns after posedge.
  task automatic cyc();
    @(negedge CLK);
    if (en) compare_model();
    @(posedge CLK);
    model_step();
    #2;
  endtask

  task automatic pulse(input int p, input int b);
    case (b)
      0: bl[p] = 1'b1;
      1: bu[p] = 1'b1;
      2: bd[p] = 1'b1;
      default: br[p] = 1'b1;
    endcase
    cyc();
    bl[p] = 1'b0; bu[p] = 1'b0; bd[p] = 1'b0; br[p] = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    // 1: reset with player 0 holding L; no request after release
    bl[0] = 1'b1;
    repeat (3) cyc();
    RESET = 1'b1;
    repeat (3) cyc();
    bl[0] = 1'b0;
    cyc();
    chk("t1_state0", 8'(nav0.Navigation_State), 8'h00);
    chk("t1_state1", 8'(nav1.Navigation_State), 8'h00);
    chk("t1_full",   8'(nav0.QUEUE_FULL), 8'h00);

    // 2: L then U buffered, two ticks
    pulse(0, 0);
    pulse(0, 1);
    do_tick();
    chk("t2_tick1_state", 8'(nav0.Navigation_State[1:0]), 8'h02);
    chk("t2_tick1_taken", 8'(nav0.TURN_TAKEN), 8'h01);
    do_tick();
    chk("t2_tick2_state", 8'(nav1.Navigation_State[1:0]), 8'h00);
    chk("t2_tick2_taken", 8'(nav1.TURN_TAKEN), 8'h01);
    cyc();
    chk("t2_taken_off", 8'(nav0.TURN_TAKEN), 8'h00);

    // 3: D then U from Up; reverse only legal on dut1
    pulse(0, 2);
    pulse(0, 1);
    do_tick();
    chk("t3_norev_state", 8'(nav0.Navigation_State[1:0]), 8'h00);
    chk("t3_norev_taken", 8'(nav0.TURN_TAKEN), 8'h00);
    chk("t3_rev_state",   8'(nav1.Navigation_State[1:0]), 8'h01);
    chk("t3_rev_taken",   8'(nav1.TURN_TAKEN), 8'h01);
    do_tick();
    cyc();

    // 4: fill queue, overflow drop, push with pop while full
    pulse(0, 0); pulse(0, 1); pulse(0, 0); pulse(0, 1);
    chk("t4_full0", 8'(nav0.QUEUE_FULL), 8'h01);
    chk("t4_full1", 8'(nav1.QUEUE_FULL), 8'h01);
    bl[0] = 1'b1;
    cyc();
    bl[0] = 1'b0;
    chk("t4_drop", 8'(nav0.DROP), 8'h01);
    cyc();
    chk("t4_drop_off", 8'(nav0.DROP), 8'h00);
    bl[0] = 1'b1; tick = 1'b1;
    cyc();
    bl[0] = 1'b0; tick = 1'b0;
    chk("t4_pp_full",  8'(nav0.QUEUE_FULL), 8'h01);
    chk("t4_pp_drop",  8'(nav0.DROP), 8'h00);
    chk("t4_pp_state", 8'(nav0.Navigation_State[1:0]), 8'h02);
    repeat (4) begin do_tick(); cyc(); end
    chk("t4_drained_full",  8'(nav0.QUEUE_FULL), 8'h00);
    chk("t4_drained_state", 8'(nav0.Navigation_State), 8'h02);

    // 5: player 1 presses L and R together
    bl[1] = 1'b1; br[1] = 1'b1;
    cyc();
    bl[1] = 1'b0; br[1] = 1'b0;
    chk("t5_drop", 8'(nav0.DROP), 8'h02);
    do_tick();
    chk("t5_state", 8'(nav0.Navigation_State), 8'h0A);
    chk("t5_taken", 8'(nav1.TURN_TAKEN), 8'h02);
    cyc();

    // 6: pause holds queue and ignores ticks and edges
    pulse(0, 1);
    pulse(0, 0);
    pause = 1'b1;
    repeat (3) begin
      do_tick();
      chk("t6_pause_state", 8'(nav0.Navigation_State), 8'h0A);
      chk("t6_pause_taken", 8'(nav0.TURN_TAKEN), 8'h00);
    end
    pulse(0, 2);
    chk("t6_pause_drop", 8'(nav0.DROP), 8'h00);
    pause = 1'b0;
    cyc();
    do_tick();
    chk("t6_resume_state", 8'(nav0.Navigation_State), 8'h08);
    chk("t6_resume_taken", 8'(nav0.TURN_TAKEN), 8'h01);
    do_tick();
    chk("t6_second_state", 8'(nav0.Navigation_State), 8'h0A);
    cyc();

    // 7: reset mid-operation discards buffered turns
    pulse(1, 1);
    RESET = 1'b0;
    cyc();
    chk("t7_rst_state", 8'(nav1.Navigation_State), 8'h00);
    chk("t7_rst_drop",  8'(nav1.DROP), 8'h00);
    RESET = 1'b1;
    cyc();
    do_tick();
    chk("t7_tick_state", 8'(nav0.Navigation_State), 8'h00);
    chk("t7_tick_taken", 8'(nav0.TURN_TAKEN), 8'h00);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/navigation_turn_queue.md
Name: navigation_turn_queue

Overview:
Per-player snake direction controller and next generation of the single-player navigation FSM. It is parametrised in player count and gains several features the current FSM lacks:
- button edge detection
- a per-player FIFO of buffered turns
- turns applied only on the game's move tick
- an optional reverse-turn mode and a pause mode
It sits between the debounced button inputs and the snake position/collision logic, which consumes Navigation_State.

Parameters:
N_PLAYERS, 2, number of independent players (1..4).
QUEUE_DEPTH, 4, buffered turns per player; power of two, at least 2.
RESET_DIR, 2'b00, direction loaded on reset (00 Up, 01 Down, 10 Left, 11 Right).
ALLOW_REVERSE, 0, 0 allows perpendicular turns only; 1 also allows 180-degree turns.

Ports:
CLK  in  1  system clock; all logic is on posedge.
RESET  in  1  synchronous, active-low reset.
BINL  in  N_PLAYERS  left button level, one bit per player.
BINU  in  N_PLAYERS  up button level.
BIND  in  N_PLAYERS  down button level.
BINR  in  N_PLAYERS  right button level.
MOVE_TICK  in  1  one-cycle pulse marking a snake step.
PAUSE  in  1  freezes direction updates and request capture.
Navigation_State  out  2*N_PLAYERS  current direction; player p occupies bits [2p+1:2p].
QUEUE_FULL  out  N_PLAYERS  player queue holds QUEUE_DEPTH entries.
TURN_TAKEN  out  N_PLAYERS  one-cycle pulse when a queued turn is applied.
DROP  out  N_PLAYERS  one-cycle pulse when a valid request is discarded.

Behaviour:
- Reset (RESET=0 at a posedge):
  - every Navigation_State field = RESET_DIR; all queues empty.
  - QUEUE_FULL, TURN_TAKEN and DROP = 0.
  - edge-detector history = all 1s, so a button held through reset produces no request.
  - Reset asserted mid-operation discards queued turns on that edge.
- Edge detection: a request exists for a button when it is sampled 1 this cycle and was 0 the previous cycle. History updates every cycle, including while PAUSE=1.
- Simultaneous edges for one player: priority L > U > D > R. Only the winner is evaluated. If the winner is accepted and at least one other edge was present, DROP pulses.
- Reference direction = queue tail if the queue is non-empty, otherwise the current Navigation_State, both taken before any same-cycle pop.
- Validity:
  - ALLOW_REVERSE=0: request valid iff request[1] != reference[1] (axis change).
  - ALLOW_REVERSE=1: request valid iff request != reference.
  - Invalid requests are discarded silently (no DROP).
- Enqueue: a valid request is written at the tail. If count==QUEUE_DEPTH and no pop occurs this cycle, the request is discarded and DROP pulses.
- Pop: on MOVE_TICK=1 with PAUSE=0 and a non-empty queue:
  - head is loaded into Navigation_State; count decrements.
  - TURN_TAKEN pulses in the following cycle, coincident with the new direction.
  - At most one turn is applied per tick. Ticks with an empty queue change nothing.
- Simultaneous push and pop in one cycle: both occur and count is unchanged. A full queue with a pop accepts the push.
- PAUSE=1: MOVE_TICK is ignored, new requests are ignored without DROP, and queue contents are held.
- Latency:
  - edge at cycle t: queue/QUEUE_FULL update visible at t+1.
  - tick at cycle t: Navigation_State and TURN_TAKEN at t+1.
  - DROP is asserted at t+1 for a discard at t.
- Players are fully independent. A single MOVE_TICK/PAUSE is shared by all players.
- Pointers wrap modulo QUEUE_DEPTH. Count width is clog2(QUEUE_DEPTH)+1.

Test Plan:
1. Reset, then release with player 0 holding BINL: no request captured; Navigation_State=00 for all players; QUEUE_FULL=0.
2. Player 0 starts Up. Pulse BINL, then BINU (both before the next tick). Then issue two MOVE_TICKs. Required: L is queued; U is valid against tail Left and is queued. Tick 1 gives state=10 with a TURN_TAKEN pulse; tick 2 gives state=00 with a TURN_TAKEN pulse.
3. With ALLOW_REVERSE=0 and state Up, pulse BIND then BINU: both are rejected, queue stays empty, no DROP. Repeat with ALLOW_REVERSE=1: D is queued; after one tick the state is 01.
4. With QUEUE_DEPTH=4, enqueue 4 alternating turns: QUEUE_FULL=1. A 5th valid edge gives DROP for 1 cycle. Repeat the 5th edge in the same cycle as MOVE_TICK: it is accepted, QUEUE_FULL stays 1, no DROP.
5. Player 1 presses BINL and BINR in the same cycle from state Up: Left is queued and DROP pulses. Player 0 is unaffected.
6. PAUSE=1 with 2 queued turns: 3 ticks leave state unchanged, and new button edges are ignored. After PAUSE=0, the next tick applies the first queued turn.
